// File: rtl/router_pkg.sv
// Shared definitions for the router input controller: sizes, header layout and FSM states.
package router_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_PORTS  = 3;
    localparam int TIMEOUT    = 30;
    localparam int ADDR_W     = 2;
    localparam int LEN_W      = DATA_WIDTH - ADDR_W;
    localparam int TMR_W      = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_HEADER,
        LOAD_DATA,
        CHECK,
        DROP
    } ctrl_state_e;

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[DATA_WIDTH-1:ADDR_W];
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr == ADDR_W'(i)) sel[i] = 1'b1;
        end
        return sel;
    endfunction
endpackage

// File: rtl/router_timeout.sv
// Per-output stall watchdog: pulses soft_reset_o for one cycle once a reader has left
// valid data unread for TIMEOUT consecutive cycles.
module router_timeout
    import router_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  logic read_i,
    output logic soft_reset_o
);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             sr_q, sr_d;
    logic             stalled;

    assign stalled = vld_i && !read_i;

    always_comb begin
        tmr_d = '0;
        sr_d  = 1'b0;
        if (stalled) begin
            if (tmr_q == TMR_W'(TIMEOUT - 1)) sr_d = 1'b1;
            else                              tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q <= '0;
            sr_q  <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            sr_q  <= sr_d;
        end
    end

    assign soft_reset_o = sr_q;
endmodule

// File: rtl/router_ctrl.sv
// Input-side controller of the 1x3 router: decodes headers, steers bytes into the output
// FIFOs, throttles the source with busy and checks parity/length of every packet.
module router_ctrl
    import router_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [NUM_PORTS-1:0]  fifo_full,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  read_enb,
    output logic                  busy,
    output logic [NUM_PORTS-1:0]  write_enb,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  lfd,
    output logic [NUM_PORTS-1:0]  vld_out,
    output logic [NUM_PORTS-1:0]  soft_reset,
    output logic                  err
);
    ctrl_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] xor_q, xor_d;
    logic [DATA_WIDTH-1:0] par_q, par_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [ADDR_W-1:0]     in_addr;
    logic [NUM_PORTS-1:0]  in_sel;
    logic [NUM_PORTS-1:0]  dest_sel;
    logic                  in_empty;
    logic                  dest_full;
    logic                  dest_empty;
    logic                  dest_sr;

    assign in_addr    = hdr_addr(data_in);
    assign in_sel     = port_onehot(in_addr);
    assign dest_sel   = port_onehot(addr_q);
    assign in_empty   = |(fifo_empty & in_sel);
    assign dest_full  = |(fifo_full & dest_sel);
    assign dest_empty = |(fifo_empty & dest_sel);
    assign dest_sr    = |(soft_reset & dest_sel);

    assign vld_out = ~fifo_empty;
    assign err     = err_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tmo
        router_timeout u_tmo (
            .clk_i       (clock),
            .rst_i       (reset),
            .vld_i       (vld_out[i]),
            .read_i      (read_enb[i]),
            .soft_reset_o(soft_reset[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        xor_d      = xor_q;
        par_d      = par_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        busy       = 1'b0;
        write_enb  = '0;
        fifo_wdata = '0;
        lfd        = 1'b0;

        case (state_q)
            DECODE: begin
                if (pkt_valid) begin
                    hdr_d  = data_in;
                    addr_d = in_addr;
                    len_d  = hdr_len(data_in);
                    xor_d  = data_in;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (in_addr == ADDR_INVALID) begin
                        state_d = DROP;
                        err_d   = 1'b1;
                    end else if (!in_empty) begin
                        state_d = WAIT_EMPTY;
                    end else begin
                        state_d = LOAD_HEADER;
                    end
                end
            end

            WAIT_EMPTY: begin
                busy = 1'b1;
                if (dest_empty) state_d = LOAD_HEADER;
            end

            LOAD_HEADER: begin
                busy = 1'b1;
                if (dest_sr) begin
                    state_d = DROP;
                    err_d   = 1'b1;
                end else if (!dest_full) begin
                    write_enb  = dest_sel;
                    lfd        = 1'b1;
                    fifo_wdata = hdr_q;
                    state_d    = LOAD_DATA;
                end
            end

            LOAD_DATA: begin
                busy = dest_full;
                // A flushed destination wins over everything: the byte is dropped, not written.
                if (dest_sr) begin
                    state_d = DROP;
                    err_d   = 1'b1;
                end else if (!dest_full) begin
                    write_enb  = dest_sel;
                    fifo_wdata = data_in;
                    if (pkt_valid) begin
                        xor_d = xor_q ^ data_in;
                        cnt_d = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);
                    end else begin
                        par_d   = data_in;
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                busy = 1'b1;
                if ((par_q != xor_q) || (cnt_q != len_q)) err_d = 1'b1;
                state_d = DECODE;
            end

            DROP: begin
                if (!pkt_valid) state_d = DECODE;
            end

            default: state_d = DECODE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DECODE;
            hdr_q   <= '0;
            xor_q   <= '0;
            par_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            xor_q   <= xor_d;
            par_q   <= par_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: a packet-level model predicts FIFO writes, busy waits
// and error flags; a monitor process pops expected writes whenever write_enb is seen.
module tb_router_ctrl;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic       busy, lfd, err;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic [7:0] fifo_wdata;

    always #5 clock = ~clock;

    router_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .read_enb  (read_enb),
        .busy      (busy),
        .write_enb (write_enb),
        .fifo_wdata(fifo_wdata),
        .lfd       (lfd),
        .vld_out   (vld_out),
        .soft_reset(soft_reset),
        .err       (err)
    );

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] data;
        logic       lfd;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pay_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         empty_hold = 0;
    bit         err_hdr_pending = 1'b0;
    bit         err_hdr_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every FIFO write must match the head of the expected-write queue.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (write_enb !== 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {29'd0, write_enb}, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_port", {29'd0, write_enb}, {29'd0, e.we});
                    chk("wr_data", {24'd0, fifo_wdata}, {24'd0, e.data});
                    chk("wr_lfd", {31'd0, lfd}, {31'd0, e.lfd});
                end
            end
        end
    end

    // Present one byte until the DUT takes it; waits returns the number of busy cycles.
    task automatic send_byte(input logic [7:0] d, input logic pv, input int full_cyc,
                             output int waits);
        int guard;
        guard = 0;
        waits = 0;
        forever begin
            @(negedge clock);
            data_in   = d;
            pkt_valid = pv;
            if (empty_hold > 0) begin
                empty_hold--;
                if (empty_hold == 0) fifo_empty = 3'b111;
            end
            fifo_full = (full_cyc > 0) ? 3'b111 : 3'b000;
            #1;
            if (err_hdr_pending) begin
                chk("err_at_hdr", {31'd0, err}, {31'd0, err_hdr_exp});
                err_hdr_pending = 1'b0;
            end
            if (full_cyc > 0) begin
                chk("busy_when_full", {31'd0, busy}, 32'd1);
                chk("no_write_when_full", {29'd0, write_enb}, 32'd0);
                full_cyc--;
            end
            if (!busy) break;
            waits++;
            guard++;
            if (guard > 200) begin
                n_chk++;
                $display("FAIL send_byte_timeout: busy still %0b after 200 cycles, expected 0", busy);
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $fatal(1, "source stuck");
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            pkt_valid = 1'b0;
            data_in   = 8'($urandom);
            fifo_full = 3'b000;
        end
    endtask

    // Sends hdr, the bytes in pay_q and a parity byte; predicts writes, waits and err.
    task automatic send_packet(input logic [7:0] hdr, input bit force_par, input logic [7:0] par_val,
                               input int hold, input int stall_byte, input int stall_n);
        logic [1:0] dest;
        logic [2:0] sel;
        logic [7:0] x, par, b;
        int         len, nb, w, exp_w, full;
        bit         exp_err;
        dest = hdr[1:0];
        len  = int'(hdr[7:2]);
        nb   = pay_q.size();
        sel  = 3'b001 << dest;
        x    = hdr;
        foreach (pay_q[i]) x ^= pay_q[i];
        par     = force_par ? par_val : x;
        exp_err = (dest == 2'd3) || (par != x) || (nb != len);
        if (dest != 2'd3) begin
            exp_q.push_back('{we: sel, data: hdr, lfd: 1'b1});
            foreach (pay_q[i]) exp_q.push_back('{we: sel, data: pay_q[i], lfd: 1'b0});
            exp_q.push_back('{we: sel, data: par, lfd: 1'b0});
            if (hold > 0) begin
                fifo_empty[dest] = 1'b0;
                empty_hold       = hold;
            end
        end
        send_byte(hdr, 1'b1, 0, w);
        chk("hdr_wait", w, 0);
        err_hdr_exp     = (dest == 2'd3);
        err_hdr_pending = 1'b1;
        for (int k = 0; k <= nb; k++) begin
            full = (dest != 2'd3 && k == stall_byte) ? stall_n : 0;
            b    = (k < nb) ? pay_q[k] : par;
            send_byte(b, (k < nb), full, w);
            exp_w = full;
            if (dest != 2'd3 && k == 0) exp_w = (hold > 0) ? hold : full + 1;
            if (!(k == 0 && hold > 0 && full > 0)) chk("byte_wait", w, exp_w);
        end
        idle(1);
        #1;
        chk("busy_in_check", {31'd0, busy}, {31'd0, (dest != 2'd3)});
        idle(1);
        #1;
        chk("busy_back_decode", {31'd0, busy}, 32'd0);
        chk("err_after_pkt", {31'd0, err}, {31'd0, exp_err});
        pay_q.delete();
    endtask

    initial begin
        int pulses, at, w, len, nb;
        logic [1:0] dest;
        reset      = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b111;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write_enb", {29'd0, write_enb}, 32'd0);
        chk("rst_lfd", {31'd0, lfd}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_soft_reset", {29'd0, soft_reset}, 32'd0);
        chk("rst_vld_out", {29'd0, vld_out}, 32'd0);
        idle(2);

        // Good packet to port 1, then bad parity, then a good one that clears err.
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 1'b0, 8'h00, 0, 99, 0);
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 1'b1, 8'h00, 0, 99, 0);
        pay_q = '{8'h44, 8'h55, 8'h66};
        send_packet(8'h0D, 1'b0, 8'h00, 0, 99, 0);

        // Invalid destination: dropped, err raised.
        pay_q = '{8'h5A};
        send_packet(8'h07, 1'b0, 8'h00, 0, 99, 0);

        // Port 2 not empty for 5 cycles, then FIFO full for 4 cycles on the second payload byte.
        pay_q = '{8'hA1, 8'hB2};
        send_packet(8'h0A, 1'b0, 8'h00, 5, 1, 4);

        // Zero-length packet.
        send_packet(8'h00, 1'b0, 8'h00, 0, 99, 0);

        // Stall watchdog on port 0.
        @(negedge clock);
        fifo_empty = 3'b110;
        read_enb   = 3'b110;
        #1;
        chk("vld_out_stall", {29'd0, vld_out}, 32'd1);
        pulses = 0;
        at     = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            #1;
            if (soft_reset[0]) begin
                pulses++;
                at = n;
            end
            chk("sr_other_ports", {30'd0, soft_reset[2:1]}, 32'd0);
        end
        chk("sr_pulse_count", pulses, 1);
        chk("sr_pulse_cycle", at, 30);
        @(negedge clock);
        read_enb = 3'b111;
        pulses   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            read_enb[0] = (n == 20);
            #1;
            if (soft_reset[0]) pulses++;
        end
        chk("sr_read_prevents", pulses, 0);
        @(negedge clock);
        fifo_empty = 3'b111;
        read_enb   = 3'b111;
        idle(2);

        // Reset in the middle of a packet.
        exp_q.push_back('{we: 3'b010, data: 8'h0D, lfd: 1'b1});
        exp_q.push_back('{we: 3'b010, data: 8'h11, lfd: 1'b0});
        exp_q.push_back('{we: 3'b010, data: 8'h22, lfd: 1'b0});
        send_byte(8'h0D, 1'b1, 0, w);
        send_byte(8'h11, 1'b1, 0, w);
        send_byte(8'h22, 1'b1, 0, w);
        @(negedge clock);
        data_in   = 8'h33;
        pkt_valid = 1'b1;
        fifo_full = 3'b111;
        reset     = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        pkt_valid = 1'b0;
        fifo_full = 3'b000;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_write_enb", {29'd0, write_enb}, 32'd0);
        chk("mid_rst_lfd", {31'd0, lfd}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_wdata", {24'd0, fifo_wdata}, 32'd0);
        chk("mid_rst_pending", exp_q.size(), 0);
        idle(3);

        // Randomized packets.
        for (int p = 0; p < 60; p++) begin
            dest = 2'($urandom_range(0, 3));
            len  = $urandom_range(0, 7);
            nb   = len;
            if ($urandom_range(0, 99) < 15) nb = len + 1;
            else if (len > 0 && $urandom_range(0, 99) < 15) nb = len - 1;
            for (int i = 0; i < nb; i++) pay_q.push_back(8'($urandom));
            send_packet({6'(len), dest}, ($urandom_range(0, 99) < 25), 8'($urandom),
                        ($urandom_range(0, 99) < 25) ? $urandom_range(2, 6) : 0,
                        $urandom_range(0, nb), $urandom_range(0, 3));
        end

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
